exu_csr_ctl: RTL

- Initiator side of the CSR access interface (csr_ren/csr_wen/csr_idx/csr_wdat/csr_rdat) served by the CSR register file.
- Takes one decoded Zicsr instruction from the execute stage through a valid/ready handshake and sequences the read-modify-write on the CSR file.
- Returns the old CSR value for rd, plus an illegal-instruction flag, through a second valid/ready handshake.
- Sits in EXU between the decode/issue logic and the CSR register file.

---
 rtl/exu_csr_pkg.sv | 31 +++
 rtl/exu_csr_alu.sv | 23 ++
 rtl/exu_csr_ctl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/exu_csr_pkg.sv
// Shared encodings for the EXU CSR controller: Zicsr funct3 values, FSM states
// and helpers that classify an incoming instruction.
package exu_csr_pkg;

    localparam logic [2:0] CSR_RW  = 3'b001;
    localparam logic [2:0] CSR_RS  = 3'b010;
    localparam logic [2:0] CSR_RC  = 3'b011;
    localparam logic [2:0] CSR_RWI = 3'b101;
    localparam logic [2:0] CSR_RSI = 3'b110;
    localparam logic [2:0] CSR_RCI = 3'b111;

    // Top two address bits equal to this mark a read-only CSR
    localparam logic [1:0] CSR_RO_FIELD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } csr_state_e;

    function automatic logic csr_func_valid(input logic [2:0] func);
        return (func == CSR_RW)  || (func == CSR_RS)  || (func == CSR_RC) ||
               (func == CSR_RWI) || (func == CSR_RSI) || (func == CSR_RCI);
    endfunction

    function automatic logic csr_func_is_rw(input logic [2:0] func);
        return (func == CSR_RW) || (func == CSR_RWI);
    endfunction

endpackage

// File: rtl/exu_csr_alu.sv
// Combinational merge of the old CSR value with the source operand to form
// the write data (write / set bits / clear bits).
module exu_csr_alu #(
    parameter int XLEN = 32
) (
    input  logic [1:0]      i_mode,
    input  logic [XLEN-1:0] i_old,
    input  logic [XLEN-1:0] i_src,
    output logic [XLEN-1:0] o_wdat
);
    import exu_csr_pkg::*;

    // Register and immediate forms share funct3[1:0]
    always_comb begin
        o_wdat = i_src;
        case (i_mode)
            CSR_RS[1:0]: o_wdat = i_old | i_src;
            CSR_RC[1:0]: o_wdat = i_old & ~i_src;
            default:     o_wdat = i_src;
        endcase
    end

endmodule

// File: rtl/exu_csr_ctl.sv
// CSR access sequencer: accepts one Zicsr op, performs the read-modify-write on
// the CSR file and returns the old value plus an illegal-instruction flag.
module exu_csr_ctl #(
    parameter int XLEN = 32,
    parameter int IDXW = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_func,
    input  logic [IDXW-1:0] op_idx,
    input  logic [XLEN-1:0] op_src,
    input  logic            op_rd_zero,
    input  logic            op_src_zero,
    input  logic            flush,
    output logic            csr_ren,
    output logic            csr_wen,
    output logic [IDXW-1:0] csr_idx,
    output logic [XLEN-1:0] csr_wdat,
    input  logic [XLEN-1:0] csr_rdat,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_ill
);
    import exu_csr_pkg::*;

    csr_state_e      r_state;
    csr_state_e      w_state_next;
    logic [IDXW-1:0] r_idx;
    logic [XLEN-1:0] r_src;
    logic [XLEN-1:0] r_old;
    logic [1:0]      r_func;
    logic            r_do_wr;
    logic            r_ill;

    logic w_accept;
    logic w_is_rw;
    logic w_do_rd;
    logic w_do_wr;
    logic w_ill;

    assign w_is_rw  = csr_func_is_rw(op_func);
    assign w_do_rd  = !(w_is_rw && op_rd_zero);
    assign w_do_wr  = w_is_rw || !op_src_zero;
    assign w_ill    = !csr_func_valid(op_func) ||
                      (w_do_wr && (op_idx[IDXW-1 -: 2] == CSR_RO_FIELD));
    assign w_accept = op_valid && op_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        op_ready     = 1'b0;
        csr_ren      = 1'b0;
        csr_wen      = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    if (w_ill)        w_state_next = ST_RESP;
                    else if (w_do_rd) w_state_next = ST_READ;
                    else              w_state_next = ST_WRITE;
                end
            end
            ST_READ: begin
                csr_ren      = 1'b1;
                w_state_next = r_do_wr ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                csr_wen      = 1'b1;
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        // A flush kills strobes and the response in the same cycle
        if (flush) begin
            w_state_next = ST_IDLE;
            op_ready     = 1'b0;
            csr_ren      = 1'b0;
            csr_wen      = 1'b0;
            rsp_valid    = 1'b0;
        end
    end

    // Old value starts at zero so write-only ops merge against 0 and report 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_src   <= '0;
            r_old   <= '0;
            r_func  <= '0;
            r_do_wr <= 1'b0;
            r_ill   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= op_idx;
            r_src   <= op_src;
            r_old   <= '0;
            r_func  <= op_func[1:0];
            r_do_wr <= w_do_wr;
            r_ill   <= w_ill;
        end else if (csr_ren) begin
            r_old   <= csr_rdat;
        end
    end

    exu_csr_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .i_mode (r_func),
        .i_old  (r_old),
        .i_src  (r_src),
        .o_wdat (csr_wdat)
    );

    assign csr_idx  = r_idx;
    assign rsp_data = r_old;
    assign rsp_ill  = r_ill;

endmodule
